// File: rtl/dso100fb_overlay_gen_if.sv
// dso100fb_overlay_gen_if: overlay pixel stream between the generator (master) and the video mixer (slave)
interface dso100fb_overlay_gen_if;
  logic        sync;
  logic        en;
  logic        valid;
  logic [31:0] data;
  modport master (input sync, input en, output valid, output data);
  modport slave (output sync, output en, input valid, input data);
endinterface

// File: rtl/dso100fb_overlay_gen.sv
// dso100fb_overlay_gen: graticule plus sample-RAM trace renderer feeding a prefetch FIFO of ARGB8888 pixels
module dso100fb_overlay_gen #(
  parameter int SAMPLE_ADDR_BITS = 10,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                        i_vidclk,
  input  logic                        i_rst,
  dso100fb_overlay_gen_if.master      ovl,
  input  logic [11:0]                 i_width,
  input  logic [11:0]                 i_height,
  input  logic [7:0]                  i_grid_pitch,
  input  logic [31:0]                 i_grid_color,
  input  logic [31:0]                 i_trace_color,
  input  logic                        i_enable,
  input  logic                        i_sample_we,
  input  logic [SAMPLE_ADDR_BITS-1:0] i_sample_addr,
  input  logic [7:0]                  i_sample_data,
  input  logic                        i_underrun_clr,
  output logic                        o_underrun,
  output logic                        o_frame_done
);
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  logic [7:0]    r_ram [2**SAMPLE_ADDR_BITS];
  logic [32:0]   r_fifo [FIFO_DEPTH];
  logic [11:0]   r_w, r_h, r_x, r_y, r_s1_x, r_s1_y;
  logic [7:0]    r_p, r_gx, r_gy, r_s1_gx, r_s1_gy, r_samp;
  logic          r_active, r_v1, r_s1_last, r_underrun, r_done;
  logic [PW-1:0] r_rd, r_wr;
  logic [CW-1:0] r_cnt;
  logic          w_empty, w_pop, w_issue, w_xend, w_last, w_in_range, w_trace, w_grid;
  logic [31:0]   w_pix;
  assign w_empty      = r_cnt == '0;
  assign w_pop        = ovl.en && !ovl.sync && !w_empty;
  assign w_issue      = r_active && !ovl.sync && (32'(r_cnt) + 32'(r_v1) < 32'(FIFO_DEPTH) + 32'(w_pop));
  assign w_xend       = r_x == r_w - 12'd1;
  assign w_last       = w_xend && r_y == r_h - 12'd1;
  assign w_in_range   = (32'(r_s1_x) >> SAMPLE_ADDR_BITS) == 32'd0;
  assign w_trace      = w_in_range && r_s1_y == {4'd0, r_samp};
  assign w_grid       = r_p != 8'd0 && (r_s1_gx == 8'd0 || r_s1_gy == 8'd0 || r_s1_x == r_w - 12'd1 || r_s1_y == r_h - 12'd1);
  assign w_pix        = !i_enable ? 32'd0 : w_trace ? i_trace_color : w_grid ? i_grid_color : 32'd0;
  assign ovl.valid    = !w_empty;
  assign ovl.data     = w_empty ? 32'd0 : r_fifo[r_rd][31:0];
  assign o_underrun   = r_underrun;
  assign o_frame_done = r_done;
  always_ff @(posedge i_vidclk) begin
    if (i_sample_we) r_ram[i_sample_addr] <= i_sample_data;
    r_samp <= r_ram[r_x[SAMPLE_ADDR_BITS-1:0]];
  end
  always_ff @(posedge i_vidclk) begin
    if (r_v1 && !ovl.sync) r_fifo[r_wr] <= {r_s1_last, w_pix};
  end
  always_ff @(posedge i_vidclk) begin
    if (i_rst) begin
      r_w        <= '0;
      r_h        <= '0;
      r_p        <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_gx       <= '0;
      r_gy       <= '0;
      r_s1_x     <= '0;
      r_s1_y     <= '0;
      r_s1_gx    <= '0;
      r_s1_gy    <= '0;
      r_s1_last  <= 1'b0;
      r_active   <= 1'b0;
      r_v1       <= 1'b0;
      r_underrun <= 1'b0;
      r_done     <= 1'b0;
      r_rd       <= '0;
      r_wr       <= '0;
      r_cnt      <= '0;
    end else begin
      r_underrun <= (ovl.en && !ovl.sync && w_empty) || (r_underrun && !i_underrun_clr);
      r_done     <= w_pop && r_fifo[r_rd][32];
      if (ovl.sync) begin
        r_w      <= i_width;
        r_h      <= i_height;
        r_p      <= i_grid_pitch;
        r_active <= i_width != 12'd0 && i_height != 12'd0;
        r_x      <= '0;
        r_y      <= '0;
        r_gx     <= '0;
        r_gy     <= '0;
        r_v1     <= 1'b0;
        r_rd     <= '0;
        r_wr     <= '0;
        r_cnt    <= '0;
      end else begin
        r_v1 <= w_issue;
        if (w_issue) begin
          r_s1_x    <= r_x;
          r_s1_y    <= r_y;
          r_s1_gx   <= r_gx;
          r_s1_gy   <= r_gy;
          r_s1_last <= w_last;
          r_x       <= w_xend ? 12'd0 : r_x + 12'd1;
          r_gx      <= (w_xend || r_gx == r_p - 8'd1) ? 8'd0 : r_gx + 8'd1;
          r_y       <= w_xend ? r_y + 12'd1 : r_y;
          r_gy      <= !w_xend ? r_gy : r_gy == r_p - 8'd1 ? 8'd0 : r_gy + 8'd1;
          r_active  <= !w_last;
        end
        if (r_v1) r_wr <= r_wr == PW'(FIFO_DEPTH - 1) ? '0 : r_wr + 1'b1;
        if (w_pop) r_rd <= r_rd == PW'(FIFO_DEPTH - 1) ? '0 : r_rd + 1'b1;
        r_cnt <= r_cnt + CW'(r_v1) - CW'(w_pop);
      end
    end
  end
endmodule

// File: tb/tb_dso100fb_overlay_gen.sv
// tb_dso100fb_overlay_gen: directed checks of raster order, grid/trace priority, back-pressure, underrun and sync handling
module tb_dso100fb_overlay_gen;
  localparam logic [31:0] GRID  = 32'hFF00FF00;
  localparam logic [31:0] TRACE = 32'hFFFF0000;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] width = '0;
  logic [11:0] height = '0;
  logic [7:0]  pitch = '0;
  logic [31:0] gcol = GRID;
  logic [31:0] tcol = TRACE;
  logic        ena = 1'b1;
  logic        we = 1'b0;
  logic        clr = 1'b0;
  logic [9:0]  addr = '0;
  logic [7:0]  sdata = '0;
  logic        underrun, done;
  logic [7:0]  smp [16];
  logic [31:0] q [$];
  int          n_chk = 0;
  int          n_err = 0;
  int          n_done = 0;
  int          n_vhi = 0;
  int          drops = 0;
  int          watch_n = 0;
  dso100fb_overlay_gen_if ovl ();
  dso100fb_overlay_gen dut (
    .i_vidclk(clk), .i_rst(rst), .ovl(ovl),
    .i_width(width), .i_height(height), .i_grid_pitch(pitch),
    .i_grid_color(gcol), .i_trace_color(tcol), .i_enable(ena),
    .i_sample_we(we), .i_sample_addr(addr), .i_sample_data(sdata),
    .i_underrun_clr(clr), .o_underrun(underrun), .o_frame_done(done)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (!rst) begin
      if (ovl.en && ovl.valid && !ovl.sync) q.push_back(ovl.data);
      if (done) n_done++;
      if (ovl.valid) n_vhi++;
      if (watch_n > 0 && q.size() > 0 && q.size() < watch_n && !ovl.valid) drops++;
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [31:0] qat(input int k);
    return k < q.size() ? q[k] : 32'hDEADBEEF;
  endfunction
  function automatic logic [31:0] exp_pix(input int x, input int y, input int w, input int h, input int p, input bit e);
    if (!e) return 32'd0;
    if (x < 16 && y == int'(smp[x])) return TRACE;
    if (p != 0 && (x % p == 0 || y % p == 0 || x == w - 1 || y == h - 1)) return GRID;
    return 32'd0;
  endfunction
  task automatic write_sample(input int a, input int d);
    we = 1'b1;
    addr = 10'(a);
    sdata = 8'(d);
    smp[a] = 8'(d);
    tick();
    we = 1'b0;
  endtask
  task automatic start(input int w, input int h, input int p, input bit e);
    width = 12'(w);
    height = 12'(h);
    pitch = 8'(p);
    ena = e;
    q.delete();
    n_done = 0;
    drops = 0;
    ovl.sync = 1'b1;
    tick();
    ovl.sync = 1'b0;
    tick();
    tick();
  endtask
  task automatic pop_frame(input string tag, input int n, input int mode);
    for (int i = 0; i < 2000 && q.size() < n; i++) begin
      ovl.en = (mode == 0) || (i % 3 == 0);
      tick();
    end
    ovl.en = 1'b0;
    tick();
    tick();
    check(tag, 32'(q.size()), 32'(n));
  endtask
  task automatic check_frame(input string tag, input int w, input int h, input int p, input bit e);
    for (int k = 0; k < w * h; k++) check(tag, qat(k), exp_pix(k % w, k / w, w, h, p, e));
  endtask
  initial begin
    int nz;
    ovl.sync = 1'b0;
    ovl.en = 1'b0;
    tick();
    tick();
    check("rst_valid", 32'(ovl.valid), 32'd0);
    check("rst_data", ovl.data, 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) write_sample(i, 200);
    start(16, 4, 4, 1'b1);
    pop_frame("grid_pops", 64, 0);
    check_frame("grid_pix", 16, 4, 4, 1'b1);
    check("grid_00", qat(0), GRID);
    check("grid_11", qat(17), 32'd0);
    check("grid_41", qat(20), GRID);
    check("grid_151", qat(31), GRID);
    check("grid_22", qat(34), 32'd0);
    check("grid_03", qat(48), GRID);
    check("grid_unf", 32'(underrun), 32'd0);
    check("grid_done", 32'(n_done), 32'd1);
    ovl.en = 1'b1;
    tick();
    ovl.en = 1'b0;
    check("drain_unf", 32'(underrun), 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("drain_clr", 32'(underrun), 32'd0);
    write_sample(5, 2);
    start(16, 4, 0, 1'b1);
    pop_frame("trace_pops", 64, 0);
    check_frame("trace_pix", 16, 4, 0, 1'b1);
    check("trace_hit", qat(37), TRACE);
    nz = 0;
    for (int k = 0; k < q.size(); k++) if (q[k] != 32'd0) nz++;
    check("trace_count", 32'(nz), 32'd1);
    start(16, 4, 4, 1'b1);
    watch_n = 64;
    pop_frame("bp_pops", 64, 1);
    watch_n = 0;
    check_frame("bp_pix", 16, 4, 4, 1'b1);
    check("bp_drops", 32'(drops), 32'd0);
    check("bp_unf", 32'(underrun), 32'd0);
    check("bp_done", 32'(n_done), 32'd1);
    write_sample(0, 0);
    width = 12'd16;
    height = 12'd4;
    pitch = 8'd0;
    q.delete();
    ovl.sync = 1'b1;
    tick();
    ovl.sync = 1'b0;
    ovl.en = 1'b1;
    tick();
    ovl.en = 1'b0;
    check("early_unf", 32'(underrun), 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("early_clr", 32'(underrun), 32'd0);
    pop_frame("mid_pops", 10, 0);
    check("mid_first", qat(0), TRACE);
    check("mid_ninth", qat(9), 32'd0);
    check("pre_sync_valid", 32'(ovl.valid), 32'd1);
    q.delete();
    ovl.sync = 1'b1;
    tick();
    ovl.sync = 1'b0;
    check("flush_valid", 32'(ovl.valid), 32'd0);
    tick();
    tick();
    pop_frame("resync_pops", 1, 0);
    check("resync_first", qat(0), TRACE);
    q.delete();
    ovl.sync = 1'b1;
    ovl.en = 1'b1;
    tick();
    ovl.sync = 1'b0;
    ovl.en = 1'b0;
    check("syncen_unf", 32'(underrun), 32'd0);
    tick();
    tick();
    pop_frame("syncen_pops", 1, 0);
    check("syncen_first", qat(0), TRACE);
    width = 12'd0;
    ovl.sync = 1'b1;
    tick();
    ovl.en = 1'b1;
    tick();
    ovl.sync = 1'b0;
    ovl.en = 1'b0;
    check("empty_syncen_unf", 32'(underrun), 32'd0);
    n_vhi = 0;
    n_done = 0;
    for (int i = 0; i < 100; i++) tick();
    check("w0_valid", 32'(n_vhi), 32'd0);
    check("w0_done", 32'(n_done), 32'd0);
    start(16, 4, 4, 1'b0);
    pop_frame("dis_pops", 64, 0);
    check_frame("dis_pix", 16, 4, 4, 1'b0);
    check("dis_unf", 32'(underrun), 32'd0);
    check("dis_done", 32'(n_done), 32'd1);
    start(16, 4, 4, 1'b1);
    tick();
    check("rst_mid_pre", 32'(ovl.valid), 32'd1);
    rst = 1'b1;
    tick();
    check("rst_mid_valid", 32'(ovl.valid), 32'd0);
    check("rst_mid_data", ovl.data, 32'd0);
    rst = 1'b0;
    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
